// File: rtl/msx_bus_pkg.sv
// Shared state type, constants and address helper for the MSX slot I/O bridge.
package msx_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDATA = 2'd2,
        HOLD  = 2'd3
    } bridge_state_t;

    localparam logic [7:0] C_RDATA_DEFAULT = 8'hFF;
    localparam logic [7:0] C_IO_ADDR_HI    = 8'h00;
    localparam int         C_TMO_W         = 4;

    // Z80 I/O ports decode only A7..A0; the internal bus sees a fixed upper byte.
    function automatic logic [15:0] io_bus_addr(input logic [7:0] port_lo);
        return {C_IO_ADDR_HI, port_lo};
    endfunction

endpackage

// File: rtl/slot_sync.sv
// Two-flop synchroniser for an asynchronous active-low slot strobe; idles high.
module slot_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; reset parks both stages at the inactive (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/msx_slot_io_bridge.sv
// Turns one Z80 slot I/O cycle into exactly one internal bus request, stretching
// /WAIT until a read byte is available and driving it back onto the slot.
module msx_slot_io_bridge #(
    parameter int RD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slot_iorq_n,
    input  logic        slot_rd_n,
    input  logic        slot_wr_n,
    input  logic [15:0] slot_a,
    input  logic [7:0]  slot_d_in,
    output logic [7:0]  slot_d_out,
    output logic        slot_d_oe,
    output logic        slot_wait_n,
    output logic        bus_io_req,
    input  logic        bus_ack,
    output logic        bus_wrt,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_rdata_en
);

    import msx_bus_pkg::*;

    localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(RD_TIMEOUT - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_MAX  = {C_TMO_W{1'b1}};
    localparam logic [C_TMO_W-1:0] C_TMO_ONE  = {{(C_TMO_W-1){1'b0}}, 1'b1};

    logic               iorq_sync_s;
    logic               rd_sync_s;
    logic               wr_sync_s;
    logic               active_s;
    logic               active_prev_r;
    logic               start_s;
    logic               released_r;
    logic               released_s;
    logic               bus_ack_r;
    logic               bus_rdata_en_r;
    logic [7:0]         bus_rdata_r;
    logic [C_TMO_W-1:0] tmo_cnt_r;
    logic               tmo_hit_s;
    bridge_state_t      state_r;
    bridge_state_t      state_nxt_s;
    bridge_state_t      cmpl_state_s;
    logic               dout_load_s;
    logic [7:0]         dout_nxt_s;
    logic               unused_addr_hi_s;

    slot_sync u_sync_iorq (.clk(clk), .reset(reset), .async_in(slot_iorq_n), .sync_out(iorq_sync_s));
    slot_sync u_sync_rd   (.clk(clk), .reset(reset), .async_in(slot_rd_n),   .sync_out(rd_sync_s));
    slot_sync u_sync_wr   (.clk(clk), .reset(reset), .async_in(slot_wr_n),   .sync_out(wr_sync_s));

    assign active_s   = !iorq_sync_s && (!rd_sync_s || !wr_sync_s);
    assign start_s    = active_s && !active_prev_r && (state_r == IDLE);
    assign tmo_hit_s  = (tmo_cnt_r >= C_TMO_LAST);
    // Once the Z80 lets go mid-transaction, the bus side finishes but the slot side is skipped.
    assign released_s = released_r || !active_s;
    assign unused_addr_hi_s = ^slot_a[15:8];

    // Next state, plus the byte (and whether) to present on the slot at read completion.
    always_comb begin
        state_nxt_s  = state_r;
        cmpl_state_s = HOLD;
        dout_nxt_s   = C_RDATA_DEFAULT;
        dout_load_s  = 1'b0;
        if (released_s) begin
            cmpl_state_s = IDLE;
        end else begin
            cmpl_state_s = HOLD;
        end
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (bus_ack_r) begin
                    if (bus_wrt) begin
                        state_nxt_s = cmpl_state_s;
                    end else begin
                        state_nxt_s = RDATA;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s = cmpl_state_s;
                    dout_nxt_s  = C_RDATA_DEFAULT;
                    dout_load_s = !bus_wrt && !released_s;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            RDATA: begin
                if (bus_rdata_en_r) begin
                    state_nxt_s = cmpl_state_s;
                    dout_nxt_s  = bus_rdata_r;
                    dout_load_s = !released_s;
                end else if (tmo_hit_s) begin
                    state_nxt_s = cmpl_state_s;
                    dout_nxt_s  = C_RDATA_DEFAULT;
                    dout_load_s = !released_s;
                end else begin
                    state_nxt_s = RDATA;
                end
            end
            HOLD: begin
                if (iorq_sync_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Registers the bus handshake inputs and the strobe-activity history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_prev_r  <= 1'b0;
            bus_ack_r      <= 1'b0;
            bus_rdata_en_r <= 1'b0;
            bus_rdata_r    <= 8'h00;
        end else begin
            active_prev_r  <= active_s;
            bus_ack_r      <= bus_ack;
            bus_rdata_en_r <= bus_rdata_en;
            bus_rdata_r    <= bus_rdata;
        end
    end

    // State register, per-state saturating timeout counter and early-release flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            tmo_cnt_r  <= {C_TMO_W{1'b0}};
            released_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                tmo_cnt_r <= {C_TMO_W{1'b0}};
            end else if (tmo_cnt_r != C_TMO_MAX) begin
                tmo_cnt_r <= tmo_cnt_r + C_TMO_ONE;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
            if (start_s) begin
                released_r <= 1'b0;
            end else if (((state_r == REQ) || (state_r == RDATA)) && !active_s) begin
                released_r <= 1'b1;
            end else begin
                released_r <= released_r;
            end
        end
    end

    // Internal bus request; address, data and direction are frozen at the start of a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_io_req  <= 1'b0;
            bus_wrt     <= 1'b0;
            bus_address <= 16'h0000;
            bus_wdata   <= 8'h00;
        end else begin
            bus_io_req <= (state_nxt_s == REQ);
            if (start_s) begin
                bus_address <= io_bus_addr(slot_a[7:0]);
                bus_wdata   <= slot_d_in;
                bus_wrt     <= !wr_sync_s;
            end else begin
                bus_address <= bus_address;
                bus_wdata   <= bus_wdata;
                bus_wrt     <= bus_wrt;
            end
        end
    end

    // Slot-side read data, its output enable and the /WAIT stretch.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_d_out  <= C_RDATA_DEFAULT;
            slot_d_oe   <= 1'b0;
            slot_wait_n <= 1'b1;
        end else begin
            if (dout_load_s) begin
                slot_d_out <= dout_nxt_s;
            end else begin
                slot_d_out <= slot_d_out;
            end
            slot_d_oe   <= (state_nxt_s == HOLD) && !bus_wrt && !rd_sync_s && !iorq_sync_s;
            slot_wait_n <= !((state_nxt_s == REQ) || (state_nxt_s == RDATA));
        end
    end

endmodule

// File: tb/tb_msx_slot_io_bridge.sv
// Randomised Z80 I/O cycles against msx_slot_io_bridge with a register-file target
// and transaction-level expectations (request count, latency, returned byte).
module tb_msx_slot_io_bridge;

    localparam int RD_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        slot_iorq_n, slot_rd_n, slot_wr_n;
    logic [15:0] slot_a;
    logic [7:0]  slot_d_in;
    logic [7:0]  slot_d_out;
    logic        slot_d_oe, slot_wait_n;
    logic        bus_io_req, bus_wrt;
    logic        bus_ack = 1'b0;
    logic [15:0] bus_address;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_rdata_en = 1'b0;

    always #5 clk = ~clk;

    msx_slot_io_bridge #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .slot_iorq_n(slot_iorq_n), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
        .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out),
        .slot_d_oe(slot_d_oe), .slot_wait_n(slot_wait_n),
        .bus_io_req(bus_io_req), .bus_ack(bus_ack), .bus_wrt(bus_wrt),
        .bus_address(bus_address), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Target model (system register file): behaviour set per transaction, totals only grow.
    logic [7:0]  regs [256];
    bit          regs_ready = 1'b0;
    int          ack_lat = 0, rdata_lat = 0;
    int          req_rises_tot = 0, req_cycles_tot = 0, unstable_tot = 0;
    int          req_age = 0, rd_cnt = 0;
    bit          req_prev = 1'b0, acked = 1'b0;
    logic [15:0] cap_addr = 16'h0000;
    logic [7:0]  cap_wdata = 8'h00;
    logic        cap_wrt = 1'b0;
    logic [7:0]  rd_idx = 8'h00;

    // Responding target: acks ack_lat cycles into a request, returns data rdata_lat cycles later.
    always @(negedge clk) begin
        if (!regs_ready) begin
            foreach (regs[i]) regs[i] = 8'($urandom);
            regs_ready = 1'b1;
        end
        bus_ack = 1'b0;
        bus_rdata_en = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                bus_rdata_en = 1'b1;
                bus_rdata = regs[rd_idx];
            end
        end
        if (bus_io_req === 1'b1) begin
            if (!req_prev) begin
                req_rises_tot++;
                cap_addr = bus_address;
                cap_wdata = bus_wdata;
                cap_wrt = bus_wrt;
                req_age = 0;
                acked = 1'b0;
            end else if (bus_address !== cap_addr || bus_wdata !== cap_wdata || bus_wrt !== cap_wrt) begin
                unstable_tot++;
            end
            req_age++;
            req_cycles_tot++;
            if (!acked && ack_lat != 0 && req_age == ack_lat) begin
                bus_ack = 1'b1;
                acked = 1'b1;
                if (cap_wrt) begin
                    regs[cap_addr[7:0]] = cap_wdata;
                end else if (rdata_lat != 0) begin
                    rd_cnt = rdata_lat;
                    rd_idx = cap_addr[7:0];
                end
            end
        end
        req_prev = (bus_io_req === 1'b1);
    end

    // Slot-side monitor: /WAIT low cycles, output-enable cycles, and oe rising without /WAIT rising.
    int   wait_low_tot = 0, oe_cyc_tot = 0, oe_rise_bad_tot = 0;
    logic oe_prev = 1'b0, wait_prev = 1'b1;
    always @(negedge clk) begin
        if (slot_wait_n === 1'b0) wait_low_tot++;
        if (slot_d_oe === 1'b1) oe_cyc_tot++;
        if (slot_d_oe === 1'b1 && oe_prev !== 1'b1 && !(wait_prev === 1'b0 && slot_wait_n === 1'b1))
            oe_rise_bad_tot++;
        oe_prev = slot_d_oe;
        wait_prev = slot_wait_n;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One Z80 I/O cycle; expectations come from the bridge's rules, not from its internals.
    task automatic z80_io(input string tag, input bit wr, input bit both, input logic [15:0] addr,
                          input logic [7:0] d, input int alat, input int rlat, input bit early);
        int r0, c0, u0, w0, o0, b0, exp_req, exp_wait, since;
        logic [7:0] exp_dout;
        bit seen_wait, done;
        ack_lat = alat;
        rdata_lat = rlat;
        exp_req = (alat == 0) ? RD_TIMEOUT : alat + 1;
        exp_wait = exp_req;
        if (!wr && alat != 0) exp_wait += (rlat == 0) ? RD_TIMEOUT : rlat;
        exp_dout = (alat == 0 || rlat == 0) ? 8'hFF : regs[addr[7:0]];
        r0 = req_rises_tot; c0 = req_cycles_tot; u0 = unstable_tot;
        w0 = wait_low_tot; o0 = oe_cyc_tot; b0 = oe_rise_bad_tot;
        slot_a = addr;
        slot_d_in = d;
        slot_iorq_n = 1'b0;
        slot_rd_n = wr ? !both : 1'b0;
        slot_wr_n = !wr;
        seen_wait = 1'b0;
        done = 1'b0;
        since = 0;
        for (int n = 0; n < 80 && !done; n++) begin
            step();
            if (early && req_rises_tot != r0) begin
                since++;
                if (since == 2) begin
                    slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
                end
            end
            if (slot_wait_n === 1'b0) seen_wait = 1'b1;
            else if (seen_wait) done = 1'b1;
        end
        check_eq({tag, "/done"}, done, 1'b1);
        check_eq({tag, "/req_count"}, req_rises_tot - r0, 1);
        check_eq({tag, "/addr"}, cap_addr, {8'h00, addr[7:0]});
        check_eq({tag, "/wrt"}, cap_wrt, wr);
        if (wr) check_eq({tag, "/wdata"}, cap_wdata, d);
        check_eq({tag, "/req_cycles"}, req_cycles_tot - c0, exp_req);
        check_eq({tag, "/wait_cycles"}, wait_low_tot - w0, exp_wait);
        check_eq({tag, "/req_stable"}, unstable_tot - u0, 0);
        if (!early && !wr) begin
            step();
            step();
            check_eq({tag, "/dout"}, slot_d_out, exp_dout);
            check_eq({tag, "/oe_hold"}, slot_d_oe, 1'b1);
            check_eq({tag, "/oe_with_wait"}, oe_rise_bad_tot - b0, 0);
        end else begin
            check_eq({tag, "/oe_never"}, oe_cyc_tot - o0, 0);
        end
        slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
        repeat (5) step();
        check_eq({tag, "/oe_off"}, slot_d_oe, 1'b0);
        check_eq({tag, "/wait_idle"}, slot_wait_n, 1'b1);
    endtask

    initial begin
        bit seen;
        bit wr, both, early;
        logic [15:0] a;
        logic [7:0] d;
        int al, rl;
        reset = 1'b1;
        slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
        slot_a = 16'h0000; slot_d_in = 8'h00;
        repeat (4) step();
        check_eq("rst/io_req", bus_io_req, 1'b0);
        check_eq("rst/wrt", bus_wrt, 1'b0);
        check_eq("rst/oe", slot_d_oe, 1'b0);
        check_eq("rst/addr", bus_address, 16'h0000);
        check_eq("rst/wdata", bus_wdata, 8'h00);
        check_eq("rst/dout", slot_d_out, 8'hFF);
        check_eq("rst/wait", slot_wait_n, 1'b1);
        reset = 1'b0;
        repeat (3) step();

        z80_io("out_f3", 1'b1, 1'b0, 16'h00F3, 8'h12, 2, 0, 1'b0);
        z80_io("in_f3", 1'b0, 1'b0, 16'h00F3, 8'h00, 2, 3, 1'b0);
        check_eq("in_f3/value", slot_d_out, 8'h12);
        z80_io("in_12f4", 1'b0, 1'b0, 16'h12F4, 8'h00, 3, 2, 1'b0);
        z80_io("in_noack", 1'b0, 1'b0, 16'h0055, 8'h00, 0, 0, 1'b0);
        check_eq("in_noack/value", slot_d_out, 8'hFF);
        z80_io("in_early", 1'b0, 1'b0, 16'h00A0, 8'h00, 4, 6, 1'b0 | 1'b1);
        z80_io("in_after", 1'b0, 1'b0, 16'h00F3, 8'h00, 1, 1, 1'b0);
        check_eq("in_after/value", slot_d_out, 8'h12);

        ack_lat = 0; rdata_lat = 0;
        slot_a = 16'h0077; slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (bus_io_req === 1'b1) seen = 1'b1;
        end
        check_eq("rstmid/req_seen", seen, 1'b1);
        step();
        reset = 1'b1;
        step();
        check_eq("rstmid/io_req", bus_io_req, 1'b0);
        check_eq("rstmid/wait", slot_wait_n, 1'b1);
        check_eq("rstmid/oe", slot_d_oe, 1'b0);
        check_eq("rstmid/addr", bus_address, 16'h0000);
        slot_iorq_n = 1'b1; slot_rd_n = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();
        z80_io("after_rst", 1'b1, 1'b1, 16'hBE3C, 8'h5A, 3, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(1, 0));
            both = wr && ($urandom_range(3, 0) == 0);
            a = 16'($urandom);
            d = 8'($urandom);
            al = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(10, 1));
            rl = ($urandom_range(5, 0) == 0) ? 0 : int'($urandom_range(10, 1));
            early = (al == 0 || al >= 4) && ($urandom_range(5, 0) == 0);
            z80_io("rnd", wr, both, a, d, al, rl, early);
            repeat ($urandom_range(3, 1)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
